// File: rtl/adsr_env.sv
// ADSR envelope generator that advances once per sample strobe and scales each
// incoming sample by the pre-update envelope, presenting the result one cycle later.
module adsr_env #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ENV_BITS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gate,
  input  logic [ENV_BITS-1:0]        attack_step,
  input  logic [ENV_BITS-1:0]        decay_step,
  input  logic [ENV_BITS-1:0]        sustain_level,
  input  logic [ENV_BITS-1:0]        release_step,
  input  logic signed [WIDTH-1:0]    sample_in,
  input  logic                       in_ready,
  output logic signed [WIDTH-1:0]    sample_out,
  output logic                       out_valid,
  output logic [ENV_BITS-1:0]        env_level,
  output logic [2:0]                 env_state,
  output logic                       active
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  localparam int unsigned ProdW = WIDTH + ENV_BITS + 1;
  localparam logic [ENV_BITS-1:0] EnvMax = '1;

  state_e                    state_q, state_d;
  logic [ENV_BITS-1:0]       env_q, env_d;
  logic                      gate_q;
  logic signed [WIDTH-1:0]   sample_q;
  logic                      valid_q;

  logic [ENV_BITS:0]         att_sum;
  logic [ENV_BITS-1:0]       att_next;
  logic signed [ENV_BITS:0]  dec_diff;
  logic signed [ENV_BITS:0]  rel_diff;
  logic [ENV_BITS-1:0]       rel_next;
  logic signed [ProdW-1:0]   mul_a, mul_b, product;
  logic                      unused_product;

  // One bit of headroom on each side so saturation and the sustain compare are exact.
  assign att_sum  = {1'b0, env_q} + {1'b0, attack_step};
  assign att_next = att_sum[ENV_BITS] ? EnvMax : att_sum[ENV_BITS-1:0];
  assign dec_diff = $signed({1'b0, env_q}) - $signed({1'b0, decay_step});
  assign rel_diff = $signed({1'b0, env_q}) - $signed({1'b0, release_step});
  assign rel_next = rel_diff[ENV_BITS] ? '0 : rel_diff[ENV_BITS-1:0];

  assign mul_a   = {{(ENV_BITS + 1){sample_in[WIDTH-1]}}, sample_in};
  assign mul_b   = {{WIDTH{1'b0}}, 1'b0, env_q};
  assign product = mul_a * mul_b;
  assign unused_product = ^{product[ProdW-1], product[ENV_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (in_ready) begin
      // A phase change only moves the state; the level keeps its value this tick.
      if (!gate && (state_q inside {StAttack, StDecay, StSustain})) begin
        state_d = StRelease;
      end else if (gate && !gate_q) begin
        state_d = StAttack;
      end else begin
        case (state_q)
          StIdle: env_d = '0;
          StAttack: begin
            env_d = att_next;
            if (att_next == EnvMax) state_d = StDecay;
          end
          StDecay: begin
            if (dec_diff <= $signed({1'b0, sustain_level})) begin
              env_d   = sustain_level;
              state_d = StSustain;
            end else begin
              env_d = dec_diff[ENV_BITS-1:0];
            end
          end
          StSustain: env_d = sustain_level;
          StRelease: begin
            env_d = rel_next;
            if (rel_next == '0) state_d = StIdle;
          end
          default: begin
            state_d = StIdle;
            env_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      env_q    <= '0;
      gate_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      valid_q <= in_ready;
      if (in_ready) begin
        gate_q   <= gate;
        sample_q <= product[WIDTH+ENV_BITS-1:ENV_BITS];
      end
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = valid_q;
  assign env_level  = env_q;
  assign env_state  = state_q;
  assign active     = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_env.sv
// Scoreboard bench for adsr_env: a behavioural envelope model predicts each output
// beat at stimulus time; a negedge monitor pops and compares when out_valid fires.
module tb_adsr_env;

  logic               clk = 1'b0;
  logic               reset;
  logic               gate;
  logic [15:0]        attack_step, decay_step, sustain_level, release_step;
  logic signed [15:0] sample_in;
  logic               in_ready;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic [15:0]        env_level;
  logic [2:0]         env_state;
  logic               active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int smp;
    int env;
    int st;
  } exp_t;
  exp_t exp_q[$];

  // Model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_state = 0;
  int m_env   = 0;
  bit m_gq    = 0;

  adsr_env #(.WIDTH(16), .ENV_BITS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .sample_in     (sample_in),
    .in_ready      (in_ready),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .env_state     (env_state),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_env   = 0;
    m_gq    = 0;
  endtask

  // Applies the envelope rules to the current inputs and returns the expected beat.
  task automatic model_tick(output exp_t e);
    longint prod;
    int     g, as, ds, sl, rs;
    g    = int'(gate);
    as   = int'(attack_step);
    ds   = int'(decay_step);
    sl   = int'(sustain_level);
    rs   = int'(release_step);
    prod = longint'(sample_in) * longint'(m_env);
    e.smp = int'(prod >>> 16);
    if (g == 0 && m_state >= 1 && m_state <= 3) begin
      m_state = 4;
    end else if (g == 1 && !m_gq) begin
      m_state = 1;
    end else if (m_state == 0) begin
      m_env = 0;
    end else if (m_state == 1) begin
      m_env = (m_env + as > 65535) ? 65535 : m_env + as;
      if (m_env == 65535) m_state = 2;
    end else if (m_state == 2) begin
      if (m_env - ds <= sl) begin
        m_env   = sl;
        m_state = 3;
      end else begin
        m_env = m_env - ds;
      end
    end else if (m_state == 3) begin
      m_env = sl;
    end else begin
      m_env = (m_env - rs < 0) ? 0 : m_env - rs;
      if (m_env == 0) m_state = 0;
    end
    m_gq  = (g == 1);
    e.env = m_env;
    e.st  = m_state;
  endtask

  // One clock cycle; a tick pushes the predicted beat before the sampling edge.
  task automatic cyc(input bit rdy);
    exp_t e;
    in_ready = rdy;
    if (rdy) begin
      model_tick(e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_ready = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sample_out", longint'(sample_out), e.smp);
        check("env_level", longint'(env_level), e.env);
        check("env_state", longint'(env_state), e.st);
        check("active", longint'(active), (e.st != 0) ? 1 : 0);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    gate          = 1'b0;
    attack_step   = '0;
    decay_step    = '0;
    sustain_level = '0;
    release_step  = '0;
    sample_in     = '0;
    in_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_env", env_level, 0);
    check("rst_state", env_state, 0);
    check("rst_active", active, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sample", sample_out, 0);
    reset = 1'b1;
    model_reset();

    // Idle with ticks every other cycle.
    for (int i = 0; i < 6; i++) begin
      sample_in = 16'($urandom);
      cyc(1'b1);
      cyc(1'b0);
    end
    check("idle_env", env_level, 0);
    check("idle_state", env_state, 0);

    // Attack then decay into sustain.
    gate = 1'b1; attack_step = 16'd16384; decay_step = 16'd8192;
    sustain_level = 16'd32768; sample_in = 16'sd32767;
    ticks(5);
    check("attack_peak_env", env_level, 65535);
    check("attack_peak_state", env_state, 2);
    ticks(4);
    check("sustain_env", env_level, 32768);
    check("sustain_state", env_state, 3);

    sustain_level = 16'd20000;
    ticks(1);
    check("sustain_track", env_level, 20000);
    sustain_level = 16'd32768;
    ticks(1);

    for (int i = 0; i < 10; i++) begin
      sample_in = 16'($urandom);
      cyc(1'b0);
      check("hold_env", env_level, 32768);
      check("hold_state", env_state, 3);
    end

    // Release, then retrigger from the release level.
    gate = 1'b0; release_step = 16'd16384; sample_in = -16'sd32768;
    ticks(2);
    check("release_env", env_level, 16384);
    check("release_state", env_state, 4);
    gate = 1'b1;
    ticks(1);
    check("retrig_state", env_state, 1);
    ticks(1);
    check("retrig_env", env_level, 32768);
    gate = 1'b0;
    ticks(3);
    check("release_idle", env_state, 0);
    check("release_active", active, 0);

    // Gate falls on the tick that would saturate the attack.
    gate = 1'b1;
    ticks(4);
    check("prio_pre_env", env_level, 49152);
    gate = 1'b0;
    ticks(1);
    check("prio_state", env_state, 4);
    check("prio_env", env_level, 49152);
    ticks(3);
    check("prio_idle", env_state, 0);

    // Randomised run.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      if ($urandom_range(0, 7) == 0) begin
        attack_step   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20000));
        decay_step    = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20000));
        release_step  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20000));
        sustain_level = 16'($urandom);
      end
      sample_in = 16'($urandom);
      cyc($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a decay.
    gate = 1'b0;
    release_step = 16'd65535;
    ticks(3);
    gate = 1'b1; attack_step = 16'd65535; decay_step = 16'd100; sustain_level = 16'd0;
    ticks(4);
    check("pre_reset_state", env_state, 2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_env", env_level, 0);
    check("arst_state", env_state, 0);
    check("arst_active", active, 0);
    check("arst_valid", out_valid, 0);
    check("arst_sample", sample_out, 0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    attack_step = 16'd1000;
    ticks(2);
    check("restart_env", env_level, 1000);
    check("restart_state", env_state, 1);

    cyc(1'b0);
    cyc(1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
